// File: rtl/cell_row_decoder.sv
// Rebuilds 40-cell board rows from the VGA cell-drawing pixel stream and keeps a live-cell count.
// Optional feature macro CELL_CHECK_EN adds a sticky mismatch flag for non-anchor pixel consistency.
module cell_row_decoder #(
    parameter int unsigned COLS        = 40,
    parameter int unsigned ROWS        = 32,
    parameter logic [2:0]  LIVE_COLOUR = 3'b000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            plot,
    input  logic [7:0]      x_in,
    input  logic [6:0]      y_in,
    input  logic [2:0]      c_in,
    input  logic            row_ready,
    input  logic            clear_count,
    output logic [COLS-1:0] row_out,
    output logic [4:0]      row_idx,
    output logic            row_valid,
    output logic [11:0]     live_count,
`ifdef CELL_CHECK_EN
    output logic            mismatch,
`endif
    output logic            overrun,
    output logic            abandon
);
    localparam int unsigned COL_W = 6;
    localparam int unsigned ROW_W = 5;
    localparam int unsigned CNT_W = 12;
    localparam int unsigned POP_W = 7;
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_ASSEMBLE = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state_q, state_nxt;
    logic [COLS-1:0]  asm_q, asm_nxt;
    logic [COLS-1:0]  seen_q, seen_nxt;
    logic [ROW_W-1:0] cur_row_q, cur_row_nxt;

    logic [COL_W-1:0] col_c;
    logic [ROW_W-1:0] row_c;
    logic             anchor_c, in_range_c, live_c;
    logic [COLS-1:0]  col_mask_c, asm_mask_c, cell_word_c;
    logic             complete_c, abandon_set_c, load_c;
    logic [POP_W-1:0] pop_c;
    logic [CNT_W:0]   sum_c;

    // Pixel decode: one 4x4 pixel group per cell, anchor at the group's top-left
    assign col_c       = x_in[7:2];
    assign row_c       = y_in[6:2];
    assign anchor_c    = (x_in[1:0] == 2'b00) && (y_in[1:0] == 2'b00);
    assign in_range_c  = ({1'b0, col_c} < 7'(COLS)) && ({1'b0, row_c} < 6'(ROWS));
    assign live_c      = (c_in == LIVE_COLOUR);
    assign col_mask_c  = COLS'(1) << col_c;
    assign asm_mask_c  = COLS'(1) << (COL_W'(COLS - 1) - col_c);
    assign cell_word_c = live_c ? asm_mask_c : '0;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            asm_q     <= '0;
            seen_q    <= '0;
            cur_row_q <= '0;
        end else begin
            state_q   <= state_nxt;
            asm_q     <= asm_nxt;
            seen_q    <= seen_nxt;
            cur_row_q <= cur_row_nxt;
        end
    end

    // Assembly next-state; asm_nxt/cur_row_nxt hold the completed row on the completion cycle
    always_comb begin
        state_nxt     = state_q;
        asm_nxt       = asm_q;
        seen_nxt      = seen_q;
        cur_row_nxt   = cur_row_q;
        abandon_set_c = 1'b0;
        complete_c    = 1'b0;
        if (plot && anchor_c && in_range_c) begin
            case (state_q)
                S_IDLE: begin
                    state_nxt   = S_ASSEMBLE;
                    cur_row_nxt = row_c;
                    asm_nxt     = cell_word_c;
                    seen_nxt    = col_mask_c;
                end
                S_ASSEMBLE: begin
                    if (row_c == cur_row_q) begin
                        asm_nxt  = (asm_q & ~asm_mask_c) | cell_word_c;
                        seen_nxt = seen_q | col_mask_c;
                    end else begin
                        abandon_set_c = 1'b1;
                        cur_row_nxt   = row_c;
                        asm_nxt       = cell_word_c;
                        seen_nxt      = col_mask_c;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
            complete_c = (seen_nxt == '1);
            if (complete_c) begin
                state_nxt = S_IDLE;
                seen_nxt  = '0;
            end
        end
    end

    assign load_c = complete_c && (!row_valid || row_ready);
    assign pop_c  = POP_W'($countones(asm_nxt));
    assign sum_c  = (CNT_W + 1)'(live_count) + (CNT_W + 1)'(pop_c);

    // Single-entry output register, sticky flags and saturating live-cell count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_out    <= '0;
            row_idx    <= '0;
            row_valid  <= 1'b0;
            live_count <= '0;
            overrun    <= 1'b0;
            abandon    <= 1'b0;
        end else begin
            if (load_c) begin
                row_out   <= asm_nxt;
                row_idx   <= cur_row_nxt;
                row_valid <= 1'b1;
            end else if (row_valid && row_ready) begin
                row_valid <= 1'b0;
            end
            if (complete_c && !load_c) begin
                overrun <= 1'b1;
            end
            if (abandon_set_c) begin
                abandon <= 1'b1;
            end
            if (clear_count) begin
                live_count <= '0;
            end else if (load_c) begin
                live_count <= sum_c[CNT_W] ? CNT_MAX : sum_c[CNT_W-1:0];
            end
        end
    end

`ifdef CELL_CHECK_EN
    logic check_hit_c;
    logic stored_bit_c;

    assign stored_bit_c = asm_q[COL_W'(COLS - 1) - col_c];
    assign check_hit_c  = plot && !anchor_c && in_range_c && (state_q == S_ASSEMBLE) &&
                          (row_c == cur_row_q) && seen_q[col_c] && (live_c != stored_bit_c);

    // Sticky flag: a non-anchor pixel disagreed with its anchored cell
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else if (check_hit_c) begin
            mismatch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cell_row_decoder.sv
// Directed-vector bench for cell_row_decoder with a queue-based row scoreboard.
module tb_cell_row_decoder;
    localparam logic [2:0] LIVE = 3'b000;
    localparam logic [2:0] DEAD = 3'b111;

    typedef struct packed {
        logic [4:0]  idx;
        logic [39:0] row;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        plot;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  c_in;
    logic        row_ready;
    logic        clear_count;
    logic [39:0] row_out;
    logic [4:0]  row_idx;
    logic        row_valid;
    logic [11:0] live_count;
    logic        overrun;
    logic        abandon;
`ifdef CELL_CHECK_EN
    logic        mismatch;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t mon_e;
    logic [39:0] exp_row;

    cell_row_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .plot        (plot),
        .x_in        (x_in),
        .y_in        (y_in),
        .c_in        (c_in),
        .row_ready   (row_ready),
        .clear_count (clear_count),
        .row_out     (row_out),
        .row_idx     (row_idx),
        .row_valid   (row_valid),
        .live_count  (live_count),
`ifdef CELL_CHECK_EN
        .mismatch    (mismatch),
`endif
        .overrun     (overrun),
        .abandon     (abandon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic [2:0] c);
        plot = 1'b1;
        x_in = 8'(x);
        y_in = 7'(y);
        c_in = c;
        @(posedge clk);
        #1;
        plot = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        plot  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every accepted row must match the oldest expected row
    always @(negedge clk) begin
        if (!reset && row_valid && row_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_row: got idx %0d row %h, expected no row", row_idx, row_out);
            end else begin
                mon_e = q.pop_front();
                if (row_idx !== mon_e.idx || row_out !== mon_e.row) begin
                    bad++;
                    $display("FAIL row_data: got idx %0d row %h expected idx %0d row %h",
                             row_idx, row_out, mon_e.idx, mon_e.row);
                end
            end
        end
    end

    initial begin
        plot = 1'b0; x_in = '0; y_in = '0; c_in = '0;
        row_ready = 1'b0; clear_count = 1'b0; reset = 1'b0;
        #2;
        do_reset();
        chk("rst_row_out", 64'(row_out), 64'h0);
        chk("rst_row_idx", 64'(row_idx), 64'h0);
        chk("rst_valid", 64'(row_valid), 64'h0);
        chk("rst_live", 64'(live_count), 64'h0);
        chk("rst_flags", 64'({overrun, abandon}), 64'h0);

        // Row 3, alternating cells, full pixel groups
        row_ready = 1'b1;
        q.push_back('{idx: 5'd3, row: 40'hAAAAAAAAAA});
        for (int col = 0; col < 40; col++) begin
            for (int dy = 0; dy < 4; dy++) begin
                for (int dx = 0; dx < 4; dx++) begin
                    pix(col * 4 + dx, 12 + dy, (col % 2 == 0) ? LIVE : DEAD);
                    if (col == 38 && dx == 0 && dy == 0) chk("t1_not_yet", 64'(row_valid), 64'h0);
                    if (col == 39 && dx == 0 && dy == 0) begin
                        chk("t1_valid_rise", 64'(row_valid), 64'h1);
                        chk("t1_row_out", 64'(row_out), 64'hAAAAAAAAAA);
                        chk("t1_row_idx", 64'(row_idx), 64'd3);
                    end
                    if (col == 39 && dx == 1 && dy == 0) chk("t1_valid_fall", 64'(row_valid), 64'h0);
                end
            end
        end
        chk("t1_live", 64'(live_count), 64'd20);
        chk("t1_abandon", 64'(abandon), 64'h0);
        clear_count = 1'b1;
        idle(1);
        clear_count = 1'b0;
        chk("t1_clear", 64'(live_count), 64'd0);

        // Rows 0 and 1 all live with consumer stalled: second row overruns
        do_reset();
        row_ready = 1'b0;
        q.push_back('{idx: 5'd0, row: 40'hFFFFFFFFFF});
        for (int col = 0; col < 40; col++) pix(col * 4, 0, LIVE);
        chk("t2_valid0", 64'(row_valid), 64'h1);
        for (int col = 0; col < 40; col++) pix(col * 4, 4, LIVE);
        chk("t2_hold_row", 64'(row_out), 64'hFFFFFFFFFF);
        chk("t2_hold_idx", 64'(row_idx), 64'd0);
        chk("t2_overrun", 64'(overrun), 64'h1);
        chk("t2_live", 64'(live_count), 64'd40);
        idle(3);
        chk("t2_still_valid", 64'(row_valid), 64'h1);
        chk("t2_still_idx", 64'(row_idx), 64'd0);
        row_ready = 1'b1;
        idle(1);
        chk("t2_valid_fall", 64'(row_valid), 64'h0);
        chk("t2_overrun_sticky", 64'(overrun), 64'h1);

        // Abandon row 5 after 10 anchors, row 6 completes
        do_reset();
        row_ready = 1'b1;
        exp_row = '0;
        for (int col = 0; col < 40; col += 3) exp_row[39 - col] = 1'b1;
        q.push_back('{idx: 5'd6, row: exp_row});
        for (int col = 0; col < 10; col++) pix(col * 4, 20, LIVE);
        chk("t3_no_abandon_yet", 64'(abandon), 64'h0);
        for (int col = 0; col < 40; col++) begin
            pix(col * 4, 24, (col % 3 == 0) ? LIVE : DEAD);
            if (col == 0) chk("t3_abandon", 64'(abandon), 64'h1);
        end
        idle(1);
        chk("t3_live", 64'(live_count), 64'd14);

        // Out-of-range column and non-anchor row-31 pixel are ignored
        do_reset();
        q.push_back('{idx: 5'd2, row: 40'h7FFFFFFFFF});
        pix(0, 8, DEAD);
        pix(200, 0, LIVE);
        chk("t4_x200_ignored", 64'(abandon), 64'h0);
        pix(0, 127, LIVE);
        chk("t4_y127_ignored", 64'(abandon), 64'h0);
        for (int col = 1; col < 40; col++) pix(col * 4, 8, LIVE);
        idle(1);
        chk("t4_live", 64'(live_count), 64'd39);

        // Duplicate col 7 anchor: last write wins, all 40 columns still required
        do_reset();
        q.push_back('{idx: 5'd4, row: 40'hFEFFFFFFFF});
        for (int col = 0; col < 39; col++) begin
            pix(col * 4, 16, LIVE);
            if (col == 7) pix(col * 4, 16, DEAD);
        end
        chk("t5_incomplete", 64'(row_valid), 64'h0);
        pix(39 * 4, 16, LIVE);
        chk("t5_valid", 64'(row_valid), 64'h1);
        chk("t5_row_out", 64'(row_out), 64'hFEFFFFFFFF);
        idle(1);
        chk("t5_live", 64'(live_count), 64'd39);

        // Reset mid-row discards the partial row silently
        do_reset();
        pix(8, 0, LIVE);
`ifdef CELL_CHECK_EN
        pix(9, 1, DEAD);
        chk("t6_mismatch", 64'(mismatch), 64'h1);
`endif
        do_reset();
`ifdef CELL_CHECK_EN
        chk("t6_mismatch_clr", 64'(mismatch), 64'h0);
`endif
        q.push_back('{idx: 5'd1, row: 40'h0});
        for (int col = 0; col < 40; col++) pix(col * 4, 4, DEAD);
        idle(1);
        chk("t6_flags", 64'({overrun, abandon}), 64'h0);
        chk("t6_live", 64'(live_count), 64'd0);

        idle(2);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cell_row_decoder.md
Name: cell_row_decoder

Overview:
- Receiving end of the cell-drawing pixel stream (x, y, colour, plot) that the board datapath sends to the VGA adapter.
- Decodes the stream back into 40-bit board row words (one bit per cell) and hands completed rows to a consumer over a valid/ready handshake.
- Keeps a running live-cell count.
- Used for board readback, scoreboarding and frame-to-board verification.

Parameters:
- COLS, 40: cells per row. Row word width; bit (COLS-1-col) holds column col.
- ROWS, 32: rows per board. Row index width is 5.
- LIVE_COLOUR, 3'b000: colour value decoded as a live cell. Any other colour decodes as dead.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- plot  in  1  pixel strobe; x_in/y_in/c_in valid this cycle
- x_in  in  8  pixel x
- y_in  in  7  pixel y
- c_in  in  3  pixel colour
- row_ready  in  1  consumer accepts row_out this cycle
- clear_count  in  1  synchronous clear of live_count
- row_out  out  COLS  decoded row word
- row_idx  out  5  row number of row_out
- row_valid  out  1  row_out/row_idx hold a completed row
- live_count  out  12  live cells in all rows handed off since reset/clear
- overrun  out  1  sticky: completed row dropped because output was still full
- abandon  out  1  sticky: partial row discarded

Behaviour:
- Reset: row_out=0, row_idx=0, row_valid=0, live_count=0, overrun=0, abandon=0, assembly state IDLE, seen mask=0.
- Decode on plot:
  - col = x_in[7:2], row = y_in[6:2].
  - Anchor pixel = x_in[1:0]==0 and y_in[1:0]==0. Only anchors update the row.
  - Pixels with col>=COLS or row>=ROWS are ignored entirely.
- Assembly FSM:
  - IDLE: on an anchor, go to ASSEMBLE. Set cur_row=row, write the decoded bit into asm[COLS-1-col], set seen[col]=1.
  - ASSEMBLE, anchor with row==cur_row: write the bit and set seen[col]. A duplicate column overwrites the bit (last write wins) and leaves seen unchanged.
  - ASSEMBLE, anchor with row!=cur_row: discard the partial row, set abandon, restart assembly with this anchor (seen = only this col).
  - Completion: the cycle seen becomes all-ones, including the anchor being written that cycle, is the completion cycle. The row is transferred on the next edge and the FSM returns to IDLE with seen cleared.
- Output register (one entry):
  - If the output register is empty, or row_valid & row_ready in the same cycle, the completed row loads. row_valid rises the cycle after the completing plot (latency 1).
  - If the output is full and row_ready=0, the completed row is dropped, overrun is set, and the output is left unchanged.
  - row_out/row_idx stay stable while row_valid=1 and row_ready=0.
  - row_valid falls after the accepting edge unless a new row loads on that same edge.
- live_count:
  - On each load into the output register, add popcount of the row.
  - Saturates at 4095.
  - clear_count takes priority over a same-cycle add; the result is 0.
- overrun/abandon clear only on reset.
- Reset mid-row discards the partial assembly with no flag.

Optional Feature:
CELL_CHECK_EN:
- Defined:
  - Adds output mismatch (1 bit, sticky, reset 0).
  - On a non-anchor in-range pixel whose col is already set in seen for cur_row, mismatch is set if decoded liveness differs from the stored asm bit.
  - Non-anchor pixels for columns not yet anchored, or for rows other than cur_row, are ignored.
- Undefined: the port is absent and non-anchor pixels are ignored as above.

Test Plan:
- Row 3, all 40 cells alternating live/dead, full 4x4 pixel groups in column order, row_ready=1 → row_valid pulses one cycle after the col 39 anchor; row_out=40'hAAAAAAAAAA (col 0 live); row_idx=3; live_count=20.
- Two complete rows (rows 0 and 1, all live) with row_ready=0 → row 0 held stable; row 1 dropped; overrun=1; live_count=40. Then row_ready=1 → row_valid falls.
- 10 anchors of row 5, then an anchor of row 6 → abandon=1; row 5 never output; row 6 completes normally.
- Pixels with x_in=200 or y_in=127 (col 50 / row 31 in range) → the x_in=200 pixel is ignored; the y_in=127 pixel is a non-anchor and leaves no state change.
- Col 7 anchor sent twice (live then dead) → final bit for col 7 = 0; completion still requires all 40 columns.
- CELL_CHECK_EN: col 2 anchor live, then pixel (x=9, y=1) white → mismatch=1. Reset mid-row then a fresh row → all outputs clean.
